// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : voice_allocator
// Purpose  : Buffers note requests from the song reader in a small FIFO and
//            hands each one to a free note_player voice, picking voices in
//            round-robin order. Voices stay busy until they pulse note_done.
// Ports    : clk           - system clock
//            reset         - asynchronous reset, active low
//            play          - dispatch enable
//            flush         - synchronous clear of pending requests
//            req_valid/req_note/req_duration/req_ready - request handshake
//            note_done     - per-voice "finished" pulses
//            load_new_note - one-hot per-voice load strobe
//            note_out/duration_out - payload for the voice being loaded
//            voice_busy    - per-voice occupancy
//            fifo_count    - number of pending requests
// Revision : 1.0 - initial release
// ============================================================================
module voice_allocator #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic                          flush,
    input  logic                          req_valid,
    input  logic [NOTE_W-1:0]             req_note,
    input  logic [DUR_W-1:0]              req_duration,
    output logic                          req_ready,
    input  logic [NUM_VOICES-1:0]         note_done,
    output logic [NUM_VOICES-1:0]         load_new_note,
    output logic [NOTE_W-1:0]             note_out,
    output logic [DUR_W-1:0]              duration_out,
    output logic [NUM_VOICES-1:0]         voice_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_GW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam logic [c_PW:0] c_DEPTH = (c_PW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ARB  = 2'd1;
    localparam logic [1:0] c_LOAD = 2'd2;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_next;
    logic [NOTE_W+DUR_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]            r_wr_ptr;
    logic [c_PW-1:0]            r_rd_ptr;
    logic [c_PW:0]              r_count;
    logic [NUM_VOICES-1:0]      r_busy;
    logic [NUM_VOICES-1:0]      w_load_mask;
    logic [c_GW-1:0]            r_last_grant;
    logic [c_GW-1:0]            r_grant;
    logic [c_GW-1:0]            w_pick;
    logic                       w_found;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_start;
    logic [NOTE_W-1:0]          r_note;
    logic [DUR_W-1:0]           r_dur;

    // Ready is forced low while held in reset so nothing is offered a slot
    // that is about to be discarded.
    assign req_ready = reset && (r_count < c_DEPTH) && !flush;
    assign w_push    = req_valid && req_ready;
    assign w_start   = play && (r_count != '0) && !flush && !(&r_busy);
    // A pop only happens out of ARB; flush turns ARB into a no-op.
    assign w_pop     = (r_state == c_ARB) && !flush && w_found;

    // Round-robin search: first free voice starting after the last grant.
    always_comb begin
        int w_idx;
        w_idx   = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_idx = (int'(r_last_grant) + 1 + i) % NUM_VOICES;
            if (!w_found && !r_busy[c_GW'(w_idx)]) begin
                w_found = 1'b1;
                w_pick  = c_GW'(w_idx);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_start) w_state_next = c_ARB;
            c_ARB:   w_state_next = w_pop ? c_LOAD : c_IDLE;
            c_LOAD:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // FSM: outputs. The load strobe is decoded from state so that an
    // asynchronous reset drops it in the same instant.
    always_comb begin
        w_load_mask = '0;
        if (r_state == c_LOAD) begin
            w_load_mask = NUM_VOICES'(1) << r_grant;
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_note, req_duration};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_busy       <= '0;
            r_last_grant <= c_GW'(NUM_VOICES - 1);
            r_grant      <= '0;
            r_note       <= '0;
            r_dur        <= '0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            if (w_pop) begin
                {r_note, r_dur} <= r_mem[r_rd_ptr];
                r_grant         <= w_pick;
            end

            if (r_state == c_LOAD) begin
                r_last_grant <= r_grant;
            end

            // Clearing first and setting second lets a load win over a
            // same-cycle done on the voice being loaded.
            r_busy <= (r_busy & ~note_done) | w_load_mask;
        end
    end

    assign load_new_note = w_load_mask;
    assign note_out      = r_note;
    assign duration_out  = r_dur;
    assign voice_busy    = r_busy;
    assign fifo_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_allocator
// Purpose  : Self-checking bench for voice_allocator. A queue-based model of
//            the allocator is compared against the DUT on every falling edge;
//            directed scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_allocator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       play = 1'b0;
    logic       flush = 1'b0;
    logic       req_valid = 1'b0;
    logic [5:0] req_note = '0;
    logic [5:0] req_duration = '0;
    logic       req_ready;
    logic [2:0] note_done = '0;
    logic [2:0] load_new_note;
    logic [5:0] note_out;
    logic [5:0] duration_out;
    logic [2:0] voice_busy;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    voice_allocator #(
        .NUM_VOICES (3),
        .NOTE_W     (6),
        .DUR_W      (6),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .play          (play),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_note      (req_note),
        .req_duration  (req_duration),
        .req_ready     (req_ready),
        .note_done     (note_done),
        .load_new_note (load_new_note),
        .note_out      (note_out),
        .duration_out  (duration_out),
        .voice_busy    (voice_busy),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: pending requests in a queue, voice occupancy as a bit set,
    // and a dispatch phase (0 waiting, 1 choosing a voice, 2 loading).
    // ------------------------------------------------------------------
    logic [11:0] m_q[$];
    logic [2:0]  m_busy  = '0;
    int          m_last  = 2;
    int          m_phase = 0;
    int          m_grant = 0;
    logic [5:0]  m_note  = '0;
    logic [5:0]  m_dur   = '0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_q.delete();
                m_busy  = '0;
                m_last  = 2;
                m_phase = 0;
                m_grant = 0;
                m_note  = '0;
                m_dur   = '0;
            end else begin
                bit         push;
                int         next_phase;
                logic [2:0] nb;
                push       = req_valid && (m_q.size() < 4) && !flush;
                next_phase = 0;
                nb         = m_busy & ~note_done;
                if (m_phase == 0) begin
                    if (play && m_q.size() > 0 && !flush && m_busy != 3'b111)
                        next_phase = 1;
                end else if (m_phase == 1) begin
                    if (!flush) begin
                        for (int k = 1; k <= 3; k++) begin
                            int v;
                            v = (m_last + k) % 3;
                            if (next_phase == 0 && (m_busy & (3'b001 << v)) == 3'b000) begin
                                m_grant    = v;
                                {m_note, m_dur} = m_q.pop_front();
                                next_phase = 2;
                            end
                        end
                    end
                end else begin
                    nb     = nb | (3'b001 << m_grant);
                    m_last = m_grant;
                end
                if (flush) m_q.delete();
                else if (push) m_q.push_back({req_note, req_duration});
                m_busy  = nb;
                m_phase = next_phase;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            logic [2:0] exp_load;
            @(negedge clk);
            if (chk_en) begin
                exp_load = (m_phase == 2) ? (3'b001 << m_grant) : 3'b000;
                check("cyc_load",  32'(load_new_note), 32'(exp_load));
                check("cyc_busy",  32'(voice_busy),    32'(m_busy));
                check("cyc_count", 32'(fifo_count),    32'(m_q.size()));
                check("cyc_ready", 32'(req_ready),
                      32'(reset && (m_q.size() < 4) && !flush));
                check("cyc_note",  32'(note_out),      32'(m_note));
                check("cyc_dur",   32'(duration_out),  32'(m_dur));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        steps(2);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_load",  32'(load_new_note), 0);
        check("rst_busy",  32'(voice_busy), 0);
        check("rst_note",  32'(note_out), 0);
        reset = 1'b1;
        step();
        check("ready_after_rst", 32'(req_ready), 1);
        play = 1'b1;

        // Single note, two-cycle latency to voice 0
        req_valid = 1'b1; req_note = 6'd12; req_duration = 6'd8;
        step();
        req_valid = 1'b0;
        check("single_count", 32'(fifo_count), 1);
        steps(2);
        check("single_load", 32'(load_new_note), 1);
        check("single_note", 32'(note_out), 12);
        check("single_dur",  32'(duration_out), 8);
        step();
        check("single_busy", 32'(voice_busy), 1);
        check("single_load_off", 32'(load_new_note), 0);

        // Fresh start, three back-to-back notes go to voices 0,1,2
        reset = 1'b0; step(); reset = 1'b1; step();
        req_valid = 1'b1; req_note = 6'd20; req_duration = 6'd1;
        step();
        req_note = 6'd21; req_duration = 6'd2;
        step();
        req_note = 6'd22; req_duration = 6'd3;
        step();
        req_valid = 1'b0;
        check("b2b_load0", 32'(load_new_note), 1);
        check("b2b_note0", 32'(note_out), 20);
        steps(3);
        check("b2b_load1", 32'(load_new_note), 2);
        check("b2b_note1", 32'(note_out), 21);
        steps(3);
        check("b2b_load2", 32'(load_new_note), 4);
        check("b2b_note2", 32'(note_out), 22);
        check("b2b_dur2",  32'(duration_out), 3);
        step();
        check("b2b_busy", 32'(voice_busy), 7);

        // All voices busy: fill FIFO, refuse a fifth, free voice 1
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_note     = 6'(30 + i);
            req_duration = (i == 0) ? 6'd0 : 6'(i + 4);
            step();
        end
        check("full_count", 32'(fifo_count), 4);
        check("full_ready", 32'(req_ready), 0);
        req_note = 6'd34;
        step();
        req_valid = 1'b0;
        check("full_refuse", 32'(fifo_count), 4);
        note_done = 3'b010;
        step();
        note_done = 3'b000;
        steps(2);
        check("free_load", 32'(load_new_note), 2);
        check("free_note", 32'(note_out), 30);
        check("free_dur0", 32'(duration_out), 0);
        check("free_count", 32'(fifo_count), 3);
        step();
        check("free_busy", 32'(voice_busy), 7);

        // Play low: busy still clears, nothing dispatched; then flush
        play = 1'b0;
        note_done = 3'b101;
        step();
        note_done = 3'b000;
        step();
        check("hold_busy",  32'(voice_busy), 2);
        check("hold_count", 32'(fifo_count), 3);
        flush = 1'b1;
        #1;
        check("flush_ready", 32'(req_ready), 0);
        step();
        flush = 1'b0;
        check("flush_count", 32'(fifo_count), 0);
        check("flush_busy",  32'(voice_busy), 2);

        // Two notes queued with play low, then released in FIFO order
        req_valid = 1'b1; req_note = 6'd40; req_duration = 6'd4;
        step();
        req_note = 6'd41; req_duration = 6'd5;
        step();
        req_valid = 1'b0;
        steps(2);
        check("paused_count", 32'(fifo_count), 2);
        check("paused_load",  32'(load_new_note), 0);
        play = 1'b1;
        steps(2);
        check("resume_load0", 32'(load_new_note), 4);
        check("resume_note0", 32'(note_out), 40);
        steps(3);
        check("resume_load1", 32'(load_new_note), 1);
        check("resume_note1", 32'(note_out), 41);
        note_done = 3'b010;
        step();
        note_done = 3'b000;

        // Flush landing on the arbitration cycle: no pop, no load
        req_valid = 1'b1; req_note = 6'd60; req_duration = 6'd9;
        step();
        req_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flusharb_load",  32'(load_new_note), 0);
        check("flusharb_count", 32'(fifo_count), 0);
        check("flusharb_note",  32'(note_out), 41);
        step();
        check("flusharb_load2", 32'(load_new_note), 0);
        check("flusharb_busy",  32'(voice_busy), 5);

        // Reset asserted during a load
        req_valid = 1'b1; req_note = 6'd50; req_duration = 6'd5;
        step();
        req_valid = 1'b0;
        steps(2);
        check("preRst_load", 32'(load_new_note), 2);
        check("preRst_note", 32'(note_out), 50);
        reset = 1'b0;
        #1;
        check("midRst_load",  32'(load_new_note), 0);
        check("midRst_note",  32'(note_out), 0);
        check("midRst_dur",   32'(duration_out), 0);
        check("midRst_busy",  32'(voice_busy), 0);
        check("midRst_count", 32'(fifo_count), 0);
        check("midRst_ready", 32'(req_ready), 0);
        step();
        reset = 1'b1;
        step();

        // Done on the voice being loaded loses; done on an idle voice ignored
        req_valid = 1'b1; req_note = 6'd63; req_duration = 6'd7;
        step();
        req_valid = 1'b0;
        steps(2);
        check("race_load", 32'(load_new_note), 1);
        note_done = 3'b001;
        step();
        note_done = 3'b000;
        check("race_busy", 32'(voice_busy), 1);
        note_done = 3'b100;
        step();
        note_done = 3'b000;
        check("idle_done_busy", 32'(voice_busy), 1);

        steps(3);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
